// File: rtl/ca_seq_pkg.sv
// Shared types and control opcodes for the cellular-automaton instruction sequencer.
// Optional single-step mode is enabled with CA_SEQ_STEP_EN.
package ca_seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IMM_W   = 12;
  localparam int unsigned GEN_W   = 16;

  localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OP_CALL = 4'h9;
  localparam logic [OPC_W-1:0] OP_RET  = 4'hA;
  localparam logic [OPC_W-1:0] OP_BR   = 4'hB;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_COMMIT,
    ST_ERROR
`ifdef CA_SEQ_STEP_EN
    , ST_STEP_WAIT
`endif
  } seq_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [IMM_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/ca_seq_return_stack.sv
// Return-address stack: register array with push/pop, combinational top-of-stack.
module ca_seq_return_stack
  import ca_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned SP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic [SP_WIDTH-1:0] sp,
  output logic                full,
  output logic                empty
);

  localparam int unsigned DEPTH = 1 << SP_WIDTH;

  logic [PC_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SP_WIDTH'(1);
    end else if (pop) begin
      sp <= sp - SP_WIDTH'(1);
    end
  end

  // Contents need no reset; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_data;
    end
  end

  assign top   = mem[sp - SP_WIDTH'(1)];
  assign full  = &sp;
  assign empty = (sp == '0);

endmodule

// File: rtl/ca_sequencer.sv
// Global instruction sequencer: fetch/exec loop, return stack, divergence branching, commit.
// Define CA_SEQ_STEP_EN to add the step input and single-instruction stepping.
module ca_sequencer
  import ca_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned SP_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef CA_SEQ_STEP_EN
  input  logic                step,
`endif
  output logic                busy,
  output logic                gen_done,
  output logic [GEN_W-1:0]    gen_count,
  output logic                prog_rd,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  output logic [INSTR_W-1:0]  instruction,
  output logic [PC_WIDTH-1:0] next_program_counter,
  output logic [SP_WIDTH-1:0] next_stack_pointer,
  output logic                execution_enable,
  input  logic                diverge_any,
  input  logic                diverge_all,
  output logic                state_commit,
  output logic                stack_error
);

  seq_state_t          state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc, imm;
  logic [INSTR_W-1:0]  instr_q;
  instr_t              dec;
  logic                push, pop, stk_err, stk_clear;
  logic [PC_WIDTH-1:0] stk_top;
  logic [SP_WIDTH-1:0] sp;
  logic                stk_full, stk_empty;

  ca_seq_return_stack #(
    .PC_WIDTH (PC_WIDTH),
    .SP_WIDTH (SP_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (stk_clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .sp        (sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign dec    = instr_t'(prog_data);
  assign pc_inc = pc + PC_WIDTH'(1);
  assign imm    = PC_WIDTH'(dec.imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, control-flow decode and the combinational broadcast outputs.
  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    push             = 1'b0;
    pop              = 1'b0;
    stk_err          = 1'b0;
    stk_clear        = 1'b0;
    execution_enable = 1'b0;
    instruction      = instr_q;

    case (state)
      ST_IDLE: begin
        stk_clear = 1'b1;
        pc_nxt    = '0;
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        instruction      = prog_data;
        execution_enable = 1'b1;
        pc_nxt           = pc_inc;
`ifdef CA_SEQ_STEP_EN
        state_nxt        = ST_STEP_WAIT;
`else
        state_nxt        = ST_FETCH;
`endif
        case (dec.opcode)
          OP_JMP: pc_nxt = imm;
          OP_CALL: begin
            if (stk_full) stk_err = 1'b1;
            else begin
              push   = 1'b1;
              pc_nxt = imm;
            end
          end
          OP_RET: begin
            if (stk_empty) stk_err = 1'b1;
            else begin
              pop    = 1'b1;
              pc_nxt = stk_top;
            end
          end
          OP_BR: begin
            if (diverge_all) begin
              pc_nxt = imm;
            end else if (diverge_any) begin
              // Mixed divergence: remember the fall-through for the masked cells.
              if (stk_full) stk_err = 1'b1;
              else begin
                push   = 1'b1;
                pc_nxt = imm;
              end
            end
          end
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = ST_COMMIT;
          end
          default: ;
        endcase
        if (stk_err) begin
          execution_enable = 1'b0;
          pc_nxt           = pc;
          state_nxt        = ST_ERROR;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_ERROR;
`ifdef CA_SEQ_STEP_EN
      ST_STEP_WAIT: if (step) state_nxt = ST_FETCH;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign next_program_counter = pc_nxt;
  assign next_stack_pointer   = push ? sp + SP_WIDTH'(1) :
                                pop  ? sp - SP_WIDTH'(1) : sp;

  // Registered status, fetch strobe and commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      instr_q      <= '0;
      busy         <= 1'b0;
      prog_rd      <= 1'b0;
      prog_addr    <= '0;
      state_commit <= 1'b0;
      gen_done     <= 1'b0;
      gen_count    <= '0;
      stack_error  <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      instr_q      <= instruction;
      busy         <= (state_nxt != ST_IDLE);
      prog_rd      <= (state_nxt == ST_FETCH);
      prog_addr    <= (state_nxt == ST_FETCH) ? pc_nxt : '0;
      state_commit <= (state_nxt == ST_COMMIT);
      gen_done     <= state_commit;
      if (state == ST_COMMIT) gen_count <= gen_count + GEN_W'(1);
      if (stk_err) stack_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ca_sequencer.sv
// Directed self-checking bench for ca_sequencer with a synchronous program memory model.
module tb_ca_sequencer;

  localparam int unsigned PCW = 12;
  localparam int unsigned SPW = 5;

  logic           clk = 1'b0;
  logic           rst, start, diverge_any, diverge_all;
`ifdef CA_SEQ_STEP_EN
  logic           step;
`endif
  logic           busy, gen_done, prog_rd, execution_enable, state_commit, stack_error;
  logic [15:0]    gen_count, instruction;
  logic [PCW-1:0] prog_addr, next_program_counter;
  logic [SPW-1:0] next_stack_pointer;
  logic [15:0]    prog_data;
  logic [15:0]    mem [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ca_sequencer #(.PC_WIDTH(PCW), .SP_WIDTH(SPW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
`ifdef CA_SEQ_STEP_EN
    .step                 (step),
`endif
    .busy                 (busy),
    .gen_done             (gen_done),
    .gen_count            (gen_count),
    .prog_rd              (prog_rd),
    .prog_addr            (prog_addr),
    .prog_data            (prog_data),
    .instruction          (instruction),
    .next_program_counter (next_program_counter),
    .next_stack_pointer   (next_stack_pointer),
    .execution_enable     (execution_enable),
    .diverge_any          (diverge_any),
    .diverge_all          (diverge_all),
    .state_commit         (state_commit),
    .stack_error          (stack_error)
  );

  always @(posedge clk) begin
    if (prog_rd) prog_data <= mem[prog_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " gen_done"}, 32'(gen_done), 0);
    check({tag, " gen_count"}, 32'(gen_count), 0);
    check({tag, " prog_rd"}, 32'(prog_rd), 0);
    check({tag, " prog_addr"}, 32'(prog_addr), 0);
    check({tag, " instruction"}, 32'(instruction), 0);
    check({tag, " next_pc"}, 32'(next_program_counter), 0);
    check({tag, " next_sp"}, 32'(next_stack_pointer), 0);
    check({tag, " exec_en"}, 32'(execution_enable), 0);
    check({tag, " commit"}, 32'(state_commit), 0);
    check({tag, " stack_error"}, 32'(stack_error), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    diverge_any = 1'b0;
    diverge_all = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  // Pulses start for one cycle; on return the sequencer is in its first FETCH.
  task automatic kick();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    clear_mem();
    prog_data = '0;
`ifdef CA_SEQ_STEP_EN
    step = 1'b0;
`endif
    do_reset();
    check_reset_outputs("reset");

`ifdef CA_SEQ_STEP_EN
    begin
      int execs;
      mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000;
      kick();
      execs = 0;
      for (int i = 0; i < 10; i++) begin
        if (execution_enable) execs++;
        tick(1);
      end
      check("step idle execs", 32'(execs), 1);
      check("step waiting busy", 32'(busy), 1);
      check("step waiting no fetch", 32'(prog_rd), 0);
      step = 1'b1; tick(1); step = 1'b0;
      check("step1 fetch", 32'(prog_rd), 1);
      check("step1 addr", 32'(prog_addr), 1);
      tick(3);
      check("step1 holds", 32'(prog_rd), 0);
      step = 1'b1; tick(1); step = 1'b0;
      check("step2 addr", 32'(prog_addr), 2);
      tick(1);
      check("step2 halt exec", 32'(instruction), 32'h0000F000);
      tick(1);
      check("step commit", 32'(state_commit), 1);
    end
`else
    // NOP, NOP, HALT: commit 7 cycles after start.
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hF000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("gen fetch0 rd", 32'(prog_rd), 1);
    check("gen fetch0 exec_en", 32'(execution_enable), 0);
    check("gen busy", 32'(busy), 1);
    tick(1);
    check("gen exec0 en", 32'(execution_enable), 1);
    check("gen exec0 next_pc", 32'(next_program_counter), 1);
    tick(4);
    check("gen halt instr", 32'(instruction), 32'h0000F000);
    check("gen pre-commit", 32'(state_commit), 0);
    tick(1);
    check("gen commit at 7", 32'(state_commit), 1);
    check("gen commit exec_en", 32'(execution_enable), 0);
    tick(1);
    check("gen commit one cycle", 32'(state_commit), 0);
    check("gen_done pulse", 32'(gen_done), 1);
    check("gen_count", 32'(gen_count), 1);
    check("gen idle busy", 32'(busy), 0);
    tick(1);
    check("gen_done ends", 32'(gen_done), 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    check("gen2 commit", 32'(state_commit), 1);
    tick(1);
    check("gen_count 2", 32'(gen_count), 2);

    // CALL / RET.
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h9010; mem[12'h001] = 16'hF000; mem[12'h010] = 16'hA000;
    kick();
    check("call fetch addr", 32'(prog_addr), 32'h000);
    tick(1);
    check("call next_sp", 32'(next_stack_pointer), 1);
    check("call next_pc", 32'(next_program_counter), 32'h010);
    tick(1);
    check("ret fetch addr", 32'(prog_addr), 32'h010);
    tick(1);
    check("ret next_sp", 32'(next_stack_pointer), 0);
    check("ret next_pc", 32'(next_program_counter), 32'h001);
    tick(1);
    check("halt fetch addr", 32'(prog_addr), 32'h001);
    tick(2);
    check("call commit", 32'(state_commit), 1);

    // BR mixed divergence pushes fall-through.
    do_reset();
    clear_mem();
    mem[12'h000] = 16'hB020; mem[12'h001] = 16'hF000; mem[12'h020] = 16'hA000;
    diverge_any = 1'b1; diverge_all = 1'b0;
    kick();
    tick(1);
    check("br mixed next_pc", 32'(next_program_counter), 32'h020);
    check("br mixed next_sp", 32'(next_stack_pointer), 1);
    check("br mixed exec_en", 32'(execution_enable), 1);
    tick(2);
    check("br mixed ret pc", 32'(next_program_counter), 32'h001);
    check("br mixed ret sp", 32'(next_stack_pointer), 0);

    // BR all-diverge jumps without push; the RET at 0x020 then underflows.
    do_reset();
    diverge_any = 1'b1; diverge_all = 1'b1;
    kick();
    tick(1);
    check("br all next_pc", 32'(next_program_counter), 32'h020);
    check("br all next_sp", 32'(next_stack_pointer), 0);
    tick(2);
    check("underflow exec_en", 32'(execution_enable), 0);
    check("underflow next_sp", 32'(next_stack_pointer), 0);
    tick(1);
    check("underflow stack_error", 32'(stack_error), 1);
    check("underflow busy", 32'(busy), 1);
    start = 1'b1; tick(3); start = 1'b0;
    check("error ignores start", 32'(prog_rd), 0);
    check("error holds busy", 32'(busy), 1);
    check("error sticky", 32'(stack_error), 1);
    do_reset();
    check("error cleared by rst", 32'(stack_error), 0);
    check("error rst busy", 32'(busy), 0);

    // BR with no divergence falls through.
    diverge_any = 1'b0; diverge_all = 1'b0;
    kick();
    tick(1);
    check("br none next_pc", 32'(next_program_counter), 32'h001);
    check("br none next_sp", 32'(next_stack_pointer), 0);

    // 32 nested CALLs: the 32nd overflows.
    do_reset();
    clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h9000 | 16'(i + 1);
    kick();
    tick(61);
    check("call31 next_sp", 32'(next_stack_pointer), 31);
    check("call31 exec_en", 32'(execution_enable), 1);
    tick(2);
    check("call32 exec_en", 32'(execution_enable), 0);
    check("call32 next_sp", 32'(next_stack_pointer), 31);
    tick(1);
    check("overflow stack_error", 32'(stack_error), 1);
    check("overflow no fetch", 32'(prog_rd), 0);
    start = 1'b1; tick(2); start = 1'b0;
    check("overflow ignores start", 32'(busy), 1);

    // PC wrap at 0xFFF, then reset in the middle of EXEC.
    do_reset();
    clear_mem();
    mem[12'h000] = 16'h8FFF;
    kick();
    tick(1);
    check("jmp next_pc", 32'(next_program_counter), 32'hFFF);
    tick(1);
    check("wrap fetch fff", 32'(prog_addr), 32'hFFF);
    tick(1);
    check("wrap next_pc", 32'(next_program_counter), 32'h000);
    tick(1);
    check("wrap fetch 000", 32'(prog_addr), 32'h000);
    tick(1);
    check("mid exec en", 32'(execution_enable), 1);
    rst = 1'b1; start = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("mid-exec rst");
    tick(1);
    check("rst beats start", 32'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ca_sequencer.md
# ca_sequencer

Global instruction sequencer for the cellular-automaton array. It fetches 16-bit instructions from program memory and broadcasts each one, with `next_program_counter`, `next_stack_pointer` and `execution_enable`, to every `cell_core`. It resolves control flow using a 32-entry return stack and the OR/AND-reduced `diverge` flags of the array. On `HALT` it ends the generation with a one-cycle state-commit pulse.

## Interface
- `PC_WIDTH`, default 12: program address width.
- `SP_WIDTH`, default 5: stack pointer width; stack depth is 2^SP_WIDTH.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a generation at PC 0; ignored unless IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `gen_done`  out  1  one-cycle pulse after a commit.
- `gen_count`  out  16  completed generations; wraps at 65535→0.
- `prog_rd`  out  1  program memory read strobe.
- `prog_addr`  out  PC_WIDTH  program memory address.
- `prog_data`  in  16  read data, valid the cycle after `prog_rd`.
- `instruction`  out  16  broadcast instruction.
- `next_program_counter`  out  PC_WIDTH  PC after the current instruction.
- `next_stack_pointer`  out  SP_WIDTH  SP after the current instruction.
- `execution_enable`  out  1  cells may write registers this cycle.
- `diverge_any`  in  1  OR of all cell `diverge` outputs.
- `diverge_all`  in  1  AND of all cell `diverge` outputs.
- `state_commit`  out  1  array latches `nextState` on this cycle.
- `stack_error`  out  1  sticky; set on overflow or underflow.

## Operation
- States: IDLE, FETCH, EXEC, COMMIT, ERROR (plus STEP_WAIT; see Configuration).
- IDLE:
  - `start` → FETCH.
  - PC ← 0, SP ← 0.
- FETCH:
  - Drive `prog_rd=1`, `prog_addr=PC`.
  - → EXEC.
- EXEC:
  - Register `prog_data` into `instruction` at entry.
  - Hold `execution_enable=1` for the whole cycle.
  - Decode `instruction[15:12]`; target address is `imm = instruction[11:0]`.
  - `JMP`: next PC ← imm.
  - `CALL`: push PC+1; next PC ← imm; SP+1.
  - `RET`: pop into next PC; SP−1.
  - `BR` with `diverge_all`: next PC ← imm.
  - `BR` with neither flag: next PC ← PC+1.
  - `BR` mixed (any and not all): push PC+1; next PC ← imm; SP+1. Cell-side masking against `next_stack_pointer` belongs to `cell_core_control`, not this block.
  - `HALT`: → COMMIT.
  - Any other opcode: next PC ← PC+1.
  - Next state after EXEC is FETCH, except `HALT` → COMMIT and errors → ERROR.
- `next_program_counter` and `next_stack_pointer` are combinational from the decode; valid throughout EXEC.
- PC arithmetic is modulo 2^PC_WIDTH: PC 4095+1 wraps to 0 with no flag.
- COMMIT:
  - `state_commit=1` for one cycle.
  - `gen_count` increments; `gen_done` pulses the following cycle.
  - → IDLE.
- Overflow (push at SP=31) or underflow (pop at SP=0):
  - Set `stack_error`.
  - Suppress `execution_enable` for that instruction; no push or pop occurs.
  - → ERROR. ERROR is left only by `rst`.

## Timing
- Non-pipelined: 2 cycles per instruction (FETCH, EXEC).
- A generation of N instructions including `HALT` takes 2N+1 cycles from `start` to `state_commit`.
- `execution_enable` is never high in FETCH, COMMIT, IDLE or ERROR.
- Reset values: all outputs 0; `gen_count` 0; `stack_error` 0; state IDLE.
- `rst` in any state, including mid-generation: return to IDLE next edge; stack contents are don't-care.
- `rst` and `start` in the same cycle: `rst` wins.
- `start` while busy: ignored, no queuing.
- `diverge_*` are sampled only in EXEC of `BR`.

## Configuration
- `CA_SEQ_STEP_EN` defined:
  - Adds input `step` (1 bit) and state STEP_WAIT between EXEC and FETCH.
  - STEP_WAIT leaves on `step=1` and keeps `busy=1`.
  - One instruction executes per `step` pulse; COMMIT is unaffected.
- `CA_SEQ_STEP_EN` undefined: no `step` port, no STEP_WAIT, free-running at 2 cycles per instruction.

## Structure
- Shared package `ca_seq_pkg`:
  - State enum `seq_state_t`.
  - Control-opcode localparams (`OP_JMP`, `OP_CALL`, `OP_RET`, `OP_BR`, `OP_HALT`), consistent with `isa.sv`.
- Sub-module `ca_seq_return_stack`:
  - 2^SP_WIDTH × PC_WIDTH register array with push/pop.
  - Combinational top-of-stack.
  - Exports `full` and `empty`.

## Test plan
- Program `NOP, NOP, HALT`, pulse `start` → `state_commit` exactly 7 cycles later; `gen_count`=1; `gen_done` one cycle after the commit.
- `CALL 0x010` at 0x000, `RET` at 0x010, `HALT` at 0x001 → fetch order 0x000, 0x010, 0x001; `next_stack_pointer` 1 during the CALL EXEC and 0 during the RET EXEC.
- `BR 0x020` with any=1/all=0 → PC+1 pushed, next PC 0x020, SP=1. With any=all=1 → next PC 0x020, SP=0. With any=all=0 → next PC 0x001.
- 32 nested CALLs → the 32nd sets `stack_error` with `execution_enable`=0 in that EXEC, state ERROR; `start` ignored until `rst`. `RET` at SP 0 → same.
- `JMP 0xFFF`, then `NOP` at 0xFFF → next fetch address 0x000; assert `rst` mid-EXEC → next cycle all outputs 0 and `busy`=0.
- With `CA_SEQ_STEP_EN`: no `step` for 10 cycles → exactly one instruction executed; each `step` pulse advances one fetch.
